unidad_logico_aritmetica_secuencial: RTL

- Parametrised, registered successor to the combinational CPU ALU.
- Keeps the same 3-bit operation encoding and the four status flags (negativo, cero, desborde, acarreo).
- Adds a start/ready/valid handshake, registered results, and iterative multi-cycle multiply and modulo (shift-add and restoring division), so wide N no longer costs combinational depth.
- Sits between the register-file read stage and writeback. The control unit stalls on listo=0.

---
 rtl/unidad_logico_aritmetica_secuencial.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/unidad_logico_aritmetica_secuencial.sv
// -----------------------------------------------------------------------------
// unidad_logico_aritmetica_secuencial
//
// Registered ALU with a start/ready/valid handshake. Single-cycle operations
// (suma, resta, desplazamiento, pasa B, pasa A, cero) complete with latency 1
// and can be issued every cycle. Multiplicacion (shift-add) and modulo
// (restoring division) iterate one bit per cycle and complete N+1 cycles after
// acceptance, so wide N costs no combinational depth.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inicio              request, accepted when inicio=1 and listo=1
//   cancelar            abort an in-flight multi-cycle operation
//   A, B  [N-1:0]       operands, sampled only at acceptance
//   Sel   [2:0]         000 suma, 001 resta, 010 mult, 011 modulo,
//                       100 shift right, 101 pasa B, 110 pasa A, 111 cero
//   listo               idle, can accept
//   valido              one-cycle pulse: C and flags updated this cycle
//   C     [N-1:0]       result, held until next completion
//   banNegativo/banCero/banDesborde/banAcarreo/banDivCero  status flags of C
// -----------------------------------------------------------------------------
module unidad_logico_aritmetica_secuencial #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic         cancelar,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   Sel,
  output logic         listo,
  output logic         valido,
  output logic [N-1:0] C,
  output logic         banNegativo,
  output logic         banCero,
  output logic         banDesborde,
  output logic         banAcarreo,
  output logic         banDivCero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_CARGA = CW'(N);
  localparam logic [CW-1:0] CNT_UNO   = CW'(1);
  localparam logic [N-1:0]  N_LIM     = N'(N);

  typedef enum logic {LIBRE, ITERA} estado_t;

  typedef enum logic [2:0] {
    OP_SUMA   = 3'b000,
    OP_RESTA  = 3'b001,
    OP_MUL    = 3'b010,
    OP_MOD    = 3'b011,
    OP_DESP   = 3'b100,
    OP_PASA_B = 3'b101,
    OP_PASA_A = 3'b110,
    OP_CERO   = 3'b111
  } op_t;

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Shared iteration register: {upper, lower} halves. For multiplication it is
  // {partial product, remaining multiplier}; for division {remainder, dividend
  // bits still to shift in / quotient bits}.
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   b_q, b_d;
  op_t            op_q, op_d;
  logic [N-1:0]   c_q, c_d;
  logic           neg_q, neg_d;
  logic           cero_q, cero_d;
  logic           desb_q, desb_d;
  logic           acar_q, acar_d;
  logic           divc_q, divc_d;
  logic           valido_q, valido_d;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [N:0]   suma, resta;
  logic [N-1:0] alu_c;
  logic         alu_v, alu_k;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    suma  = {1'b0, A} + {1'b0, B};
    resta = {1'b0, A} - {1'b0, B};
    alu_c = '0;
    alu_v = 1'b0;
    alu_k = 1'b0;
    case (Sel)
      OP_SUMA: begin
        alu_c = suma[N-1:0];
        alu_k = suma[N];
        alu_v = (A[N-1] == B[N-1]) && (suma[N-1] != A[N-1]);
      end
      OP_RESTA: begin
        alu_c = resta[N-1:0];
        alu_k = ~resta[N];  // no borrow means A >= B
        alu_v = (A[N-1] != B[N-1]) && (resta[N-1] != A[N-1]);
      end
      OP_DESP:   alu_c = (B >= N_LIM) ? '0 : (A >> B);
      OP_PASA_B: alu_c = B;
      OP_PASA_A: alu_c = A;
      default:   alu_c = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply and of restoring division
  // ---------------------------------------------------------------------------
  logic [N:0]     mul_suma;
  logic [2*N-1:0] mul_sig;
  logic [N:0]     div_r;
  logic           div_ge;
  logic [N-1:0]   div_rem;
  logic [2*N-1:0] div_sig;

  always_comb begin
    mul_suma = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? b_q : {N{1'b0}})};
    mul_sig  = {mul_suma, acc_q[N-1:1]};
    // Remainder stays below the divisor (or equals a prefix of A when B==0),
    // so the restored value always fits in N bits.
    div_r    = {acc_q[2*N-1:N], acc_q[N-1]};
    div_ge   = (div_r >= {1'b0, b_q});
    div_rem  = div_ge ? (div_r[N-1:0] - b_q) : div_r[N-1:0];
    div_sig  = {div_rem, acc_q[N-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // Control FSM and result/flag update
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    neg_d    = neg_q;
    cero_d   = cero_q;
    desb_d   = desb_q;
    acar_d   = acar_q;
    divc_d   = divc_q;
    valido_d = 1'b0;

    case (estado_q)
      LIBRE: begin
        if (inicio) begin
          if (Sel == OP_MUL || Sel == OP_MOD) begin
            // Both algorithms start from {0, A}: zero partial product /
            // remainder with A in the lower half.
            acc_d    = {{N{1'b0}}, A};
            b_d      = B;
            op_d     = op_t'(Sel);
            cnt_d    = CNT_CARGA;
            estado_d = ITERA;
          end else begin
            c_d      = alu_c;
            neg_d    = ~Sel[2] & alu_c[N-1];
            cero_d   = ~Sel[2] & (alu_c == '0);
            desb_d   = alu_v;
            acar_d   = alu_k;
            divc_d   = 1'b0;
            valido_d = 1'b1;
          end
        end
      end

      ITERA: begin
        if (cancelar) begin
          estado_d = LIBRE;
          cnt_d    = '0;
        end else begin
          acc_d = (op_q == OP_MUL) ? mul_sig : div_sig;
          cnt_d = cnt_q - CNT_UNO;
          // The last iteration is folded into the completing edge.
          if (cnt_q == CNT_UNO) begin
            estado_d = LIBRE;
            valido_d = 1'b1;
            desb_d   = 1'b0;
            if (op_q == OP_MUL) begin
              c_d    = mul_sig[N-1:0];
              acar_d = |mul_sig[2*N-1:N];
              divc_d = 1'b0;
            end else begin
              c_d    = div_sig[2*N-1:N];
              acar_d = 1'b0;
              divc_d = (b_q == '0);
            end
            neg_d  = c_d[N-1];
            cero_d = (c_d == '0);
          end
        end
      end

      default: estado_d = LIBRE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= LIBRE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= OP_SUMA;
      c_q      <= '0;
      neg_q    <= 1'b0;
      cero_q   <= 1'b0;
      desb_q   <= 1'b0;
      acar_q   <= 1'b0;
      divc_q   <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      neg_q    <= neg_d;
      cero_q   <= cero_d;
      desb_q   <= desb_d;
      acar_q   <= acar_d;
      divc_q   <= divc_d;
      valido_q <= valido_d;
    end
  end

  assign listo       = (estado_q == LIBRE);
  assign valido      = valido_q;
  assign C           = c_q;
  assign banNegativo = neg_q;
  assign banCero     = cero_q;
  assign banDesborde = desb_q;
  assign banAcarreo  = acar_q;
  assign banDivCero  = divc_q;

endmodule
